arb3_rr_ctrl: RTL and testbench

Round-robin controller that shares one instance of the three-input vote/gate datapath among three requesters. It grants exclusive use to one requester at a time, enforces a maximum hold time, and inserts a one-cycle dead gap between owners. It sits between the requester logic and the shared datapath's input mux, which is driven by `owner`.

---
 rtl/arb3_rr_ctrl_pkg.sv | 29 ++
 rtl/arb3_rr_ctrl_rr_pick3.sv | 27 ++
 rtl/arb3_rr_ctrl.sv | 111 +++++++++++
 tb/tb_arb3_rr_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/arb3_rr_ctrl_pkg.sv
// Shared encodings and small index helpers for the three-way round-robin controller.
package arb3_rr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic [1:0] OWNER_NONE = 2'd3;

  // Successor of a requester index, wrapping 2 -> 0.
  function automatic logic [1:0] next3(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // One-hot decode; OWNER_NONE decodes to all zeros.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/arb3_rr_ctrl_rr_pick3.sv
// Combinational round-robin picker: searches last+1, last+2, then last itself.
module rr_pick3
  import arb3_rr_ctrl_pkg::*;
(
  input  logic [2:0] elig,
  input  logic [1:0] last,
  output logic       found,
  output logic [1:0] win
);

  logic [1:0] pri0;
  logic [1:0] pri1;

  always_comb begin
    pri0  = next3(last);
    pri1  = next3(pri0);
    found = |elig;
    if (|(elig & onehot3(pri0))) begin
      win = pri0;
    end else if (|(elig & onehot3(pri1))) begin
      win = pri1;
    end else begin
      win = last;
    end
  end

endmodule

// File: rtl/arb3_rr_ctrl.sv
// Round-robin owner controller for a shared three-input datapath, with hold limit,
// one-cycle dead gap between owners and revocation of timed-out requesters.
module arb3_rr_ctrl
  import arb3_rr_ctrl_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CW       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout
);

  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    revoked_q, revoked_d;
  logic [2:0]    rev_set;
  logic          timeout_q, timeout_d;
  logic          busy_q;
  logic [2:0]    elig;
  logic          found;
  logic [1:0]    win;

  assign elig = req & ~revoked_q;

  rr_pick3 u_pick (
    .elig  (elig),
    .last  (last_q),
    .found (found),
    .win   (win)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    count_d   = count_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_GRANT: begin
        // A voluntary release wins over the hold limit, so no timeout in that case.
        if (!(|(req & onehot3(owner_q)))) begin
          state_d = ST_GAP;
          owner_d = OWNER_NONE;
        end else if (count_q == HOLD_LIM) begin
          state_d   = ST_GAP;
          owner_d   = OWNER_NONE;
          timeout_d = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        if (found) begin
          state_d = ST_GRANT;
          owner_d = win;
          last_d  = win;
          count_d = CW'(1);
        end else begin
          state_d = ST_IDLE;
          owner_d = OWNER_NONE;
        end
      end
    endcase
  end

  assign rev_set = timeout_d ? onehot3(owner_q) : 3'b000;
  assign grant_d = onehot3(owner_d);

  // A revoked bit survives only while its request stays high.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rev
    assign revoked_d[gi] = rev_set[gi] | (revoked_q[gi] & req[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWNER_NONE;
      last_q    <= 2'd2;
      count_q   <= '0;
      grant_q   <= 3'b000;
      revoked_q <= 3'b000;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      count_q   <= count_d;
      grant_q   <= grant_d;
      revoked_q <= revoked_d;
      timeout_q <= timeout_d;
      busy_q    <= |grant_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_arb3_rr_ctrl.sv
// Bench for arb3_rr_ctrl: three instances (HOLD_MAX 16, 4, 3), vector table,
// hand sequences, then random traffic against a behavioural model.
module tb_arb3_rr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_r   [3];
  logic [2:0] req_r   [3];
  logic [2:0] grant_w [3];
  logic [1:0] owner_w [3];
  logic       busy_w  [3];
  logic       to_w    [3];

  arb3_rr_ctrl #(.HOLD_MAX(16), .CW(5)) u16 (
    .clk(clk), .rst(rst_r[0]), .req(req_r[0]), .grant(grant_w[0]),
    .owner(owner_w[0]), .busy(busy_w[0]), .timeout(to_w[0]));
  arb3_rr_ctrl #(.HOLD_MAX(4), .CW(5)) u4 (
    .clk(clk), .rst(rst_r[1]), .req(req_r[1]), .grant(grant_w[1]),
    .owner(owner_w[1]), .busy(busy_w[1]), .timeout(to_w[1]));
  arb3_rr_ctrl #(.HOLD_MAX(3), .CW(5)) u3 (
    .clk(clk), .rst(rst_r[2]), .req(req_r[2]), .grant(grant_w[2]),
    .owner(owner_w[2]), .busy(busy_w[2]), .timeout(to_w[2]));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         sel;
    logic       rst;
    logic [2:0] req;
    logic [2:0] g;
    logic [1:0] o;
    logic       t;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int sel, input logic r, input logic [2:0] q,
                     input logic [2:0] g, input logic [1:0] o, input logic t);
    vec_t v;
    v.sel = sel; v.rst = r; v.req = q; v.g = g; v.o = o; v.t = t;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int d, input logic [2:0] g,
                       input logic [1:0] o, input logic t, input bit loud);
    logic [6:0] got;
    logic [6:0] exp;
    got = {grant_w[d], owner_w[d], busy_w[d], to_w[d]};
    exp = {g, o, |g, t};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got grant=%b owner=%0d busy=%b timeout=%b, need grant=%b owner=%0d busy=%b timeout=%b",
               name, d, grant_w[d], owner_w[d], busy_w[d], to_w[d], g, o, |g, t);
    end else if (loud) begin
      $display("ok   %s inst%0d: req=%b grant=%b owner=%0d timeout=%b",
               name, d, req_r[d], grant_w[d], owner_w[d], to_w[d]);
    end
  endtask

  task automatic drive_step(input int d, input logic r, input logic [2:0] q);
    rst_r[d] = r;
    req_r[d] = q;
    @(posedge clk);
    #1;
  endtask

  // Reference model: owner index (-1 = none), cycles held, last winner, revoked bits.
  int         m_owner [3];
  int         m_held  [3];
  int         m_last  [3];
  logic [2:0] m_rev   [3];
  logic       m_to    [3];
  int         hold_lim[3] = '{16, 4, 3};

  task automatic model_step(input int d, input logic r, input logic [2:0] q);
    logic [2:0] keep;
    if (r) begin
      m_owner[d] = -1; m_held[d] = 0; m_last[d] = 2; m_rev[d] = 3'b000; m_to[d] = 1'b0;
      return;
    end
    m_to[d] = 1'b0;
    keep = m_rev[d] & q;
    if (m_owner[d] >= 0) begin
      if (!q[m_owner[d]]) begin
        m_owner[d] = -1;
      end else if (m_held[d] == hold_lim[d]) begin
        keep[m_owner[d]] = 1'b1;
        m_to[d] = 1'b1;
        m_owner[d] = -1;
      end else begin
        m_held[d]++;
      end
    end else begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last[d] + k) % 3;
        if (q[c] && !m_rev[d][c]) begin
          m_owner[d] = c; m_last[d] = c; m_held[d] = 1;
          break;
        end
      end
    end
    m_rev[d] = keep;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_r[i] = 1'b1;
      req_r[i] = 3'b000;
    end

    // Reset, single requester, round robin on the HOLD_MAX=16 instance.
    add(0, 1, 3'b111, 3'b000, 3, 0);
    add(0, 1, 3'b111, 3'b000, 3, 0);
    add(0, 0, 3'b111, 3'b001, 0, 0);
    add(0, 0, 3'b000, 3'b000, 3, 0);
    add(0, 0, 3'b000, 3'b000, 3, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 3'b010, 3'b010, 1, 0);
    add(0, 0, 3'b000, 3'b000, 3, 0);
    add(0, 0, 3'b000, 3'b000, 3, 0);
    add(0, 1, 3'b000, 3'b000, 3, 0);
    add(0, 0, 3'b111, 3'b001, 0, 0);
    add(0, 0, 3'b111, 3'b001, 0, 0);
    add(0, 0, 3'b110, 3'b000, 3, 0);
    add(0, 0, 3'b111, 3'b010, 1, 0);
    add(0, 0, 3'b111, 3'b010, 1, 0);
    add(0, 0, 3'b101, 3'b000, 3, 0);
    add(0, 0, 3'b111, 3'b100, 2, 0);
    add(0, 0, 3'b111, 3'b100, 2, 0);
    add(0, 0, 3'b011, 3'b000, 3, 0);
    add(0, 0, 3'b111, 3'b001, 0, 0);
    add(0, 0, 3'b000, 3'b000, 3, 0);
    add(0, 0, 3'b000, 3'b000, 3, 0);
    // Timeout and revocation on the HOLD_MAX=4 instance.
    for (int i = 0; i < 4; i++) add(1, 0, 3'b101, 3'b001, 0, 0);
    add(1, 0, 3'b101, 3'b000, 3, 1);
    add(1, 0, 3'b101, 3'b100, 2, 0);
    add(1, 0, 3'b101, 3'b100, 2, 0);
    add(1, 0, 3'b001, 3'b000, 3, 0);
    add(1, 0, 3'b001, 3'b000, 3, 0);
    add(1, 0, 3'b001, 3'b000, 3, 0);
    add(1, 0, 3'b000, 3'b000, 3, 0);
    add(1, 0, 3'b001, 3'b001, 0, 0);
    add(1, 0, 3'b000, 3'b000, 3, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_step(vecs[i].sel, vecs[i].rst, vecs[i].req);
      check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].g, vecs[i].o, vecs[i].t, 1);
    end

    // Release on the same edge the hold limit is reached: no timeout, no revocation.
    for (int i = 0; i < 3; i++) begin
      drive_step(2, 0, 3'b001);
      check("lim_hold", 2, 3'b001, 0, 0, 1);
    end
    drive_step(2, 0, 3'b000);
    check("lim_release", 2, 3'b000, 3, 0, 1);
    drive_step(2, 0, 3'b001);
    check("lim_not_revoked", 2, 3'b001, 0, 0, 1);
    drive_step(2, 0, 3'b000);
    drive_step(2, 0, 3'b000);

    // Reset while requester 1 owns the resource.
    drive_step(0, 0, 3'b111);
    check("mid_grant", 0, 3'b010, 1, 0, 1);
    drive_step(0, 1, 3'b111);
    check("mid_reset", 0, 3'b000, 3, 0, 1);
    drive_step(0, 0, 3'b111);
    check("post_reset", 0, 3'b001, 0, 0, 1);

    // Random traffic on all three instances against the model.
    for (int c = 0; c < 300; c++) begin
      logic       r;
      logic [2:0] q;
      int         keep_hi;
      r = (c == 0) || ($urandom_range(0, 49) == 0);
      keep_hi = ((c / 60) % 2 == 1) ? 15 : 3;
      for (int b = 0; b < 3; b++) q[b] = ($urandom_range(0, keep_hi) != 0);
      for (int d = 0; d < 3; d++) begin
        rst_r[d] = r;
        req_r[d] = q;
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        logic [2:0] g;
        logic [1:0] o;
        model_step(d, r, q);
        g = (m_owner[d] < 0) ? 3'b000 : (3'b001 << m_owner[d]);
        o = (m_owner[d] < 0) ? 2'd3 : 2'(m_owner[d]);
        check($sformatf("rand%0d", c), d, g, o, m_to[d], 0);
      end
      $display("rand %0d: rst=%b req=%b grants=%b/%b/%b timeouts=%b%b%b",
               c, r, q, grant_w[0], grant_w[1], grant_w[2], to_w[0], to_w[1], to_w[2]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
